// File: rtl/ahb_crypto_fabric.sv
// AHB-Lite fabric for the crypto subsystem: decodes NUM_SLV engine slots plus a CSR slot,
// muxes data-phase responses, answers unmapped addresses with ERROR and aggregates interrupts.
module ahb_crypto_fabric #(
  parameter int          NUM_SLV   = 3,
  parameter logic [31:0] BASE_ADDR = 32'h2002_0000,
  parameter int          SLOT_LOG2 = 16,
  parameter bit          INT_EDGE  = 1'b1,
  parameter logic [7:0]  VERSION   = 8'h02
) (
  input  logic                   hclk,
  input  logic                   hrst_b,
  input  logic                   hsel,
  input  logic [31:0]            haddr,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [2:0]             hsize,
  input  logic [3:0]             hprot,
  input  logic [31:0]            hwdata,
  output logic [31:0]            hrdata,
  output logic                   hready,
  output logic [1:0]             hresp,
  output logic [NUM_SLV-1:0]     s_hsel,
  input  logic [32*NUM_SLV-1:0]  s_hrdata,
  input  logic [NUM_SLV-1:0]     s_hready,
  input  logic [2*NUM_SLV-1:0]   s_hresp,
  input  logic [NUM_SLV-1:0]     s_intr,
  output logic                   irq
);

  localparam logic [3:0]  NUM_SLV_4 = 4'(NUM_SLV);
  localparam logic [31:0] CSR_IDX   = 32'(NUM_SLV);

  // Data-phase owner; DP_ERR1/DP_ERR2 are the two cycles of the default-slave ERROR.
  typedef enum logic [2:0] {DP_NONE, DP_ENG, DP_CSR, DP_ERR1, DP_ERR2} dp_state_e;

  dp_state_e            state_q, state_d;
  logic [3:0]           eng_q, eng_d;
  logic [1:0]           off_q, off_d;
  logic                 wr_q, wr_d;
  logic [NUM_SLV-1:0]   mask_q, mask_d;
  logic [NUM_SLV-1:0]   pending_q, pending_d;
  logic [NUM_SLV-1:0]   intr_prev_q, intr_prev_d;
  logic                 irq_q, irq_d;

  logic [31:0]          rel_addr, idx;
  logic                 in_win, csr_wr;
  logic [NUM_SLV-1:0]   csr_wdata, w1c;
  logic                 unused_ok;

  assign unused_ok = ^{hsize, hprot, hwdata};
  assign irq       = irq_q;

  always_comb begin
    rel_addr = haddr - BASE_ADDR;
    idx      = rel_addr >> SLOT_LOG2;
    in_win   = (haddr >= BASE_ADDR) && (idx <= CSR_IDX);
    s_hsel   = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      s_hsel[i] = hsel && in_win && (idx == 32'(i));
    end
  end

  always_comb begin
    hrdata  = '0;
    hready  = 1'b1;
    hresp   = 2'b00;
    state_d = state_q;
    eng_d   = eng_q;
    off_d   = off_q;
    wr_d    = wr_q;

    case (state_q)
      DP_ENG: begin
        for (int i = 0; i < NUM_SLV; i++) begin
          if (eng_q == 4'(i)) begin
            hrdata = s_hrdata[32*i +: 32];
            hready = s_hready[i];
            hresp  = s_hresp[2*i +: 2];
          end
        end
      end
      DP_CSR: begin
        case (off_q)
          2'd0:    hrdata = 32'(pending_q);
          2'd1:    hrdata = 32'(mask_q);
          2'd2:    hrdata = 32'(s_intr);
          default: hrdata = {16'h0, VERSION, 4'h0, NUM_SLV_4};
        endcase
      end
      DP_ERR1: begin
        hready = 1'b0;
        hresp  = 2'b01;
      end
      DP_ERR2: hresp = 2'b01;
      default: ;
    endcase

    // A new address phase is only taken while the current data phase completes.
    if (hready) begin
      if (hsel && htrans[1]) begin
        wr_d  = hwrite;
        off_d = haddr[3:2];
        if (!in_win) begin
          state_d = DP_ERR1;
        end else if (idx == CSR_IDX) begin
          state_d = DP_CSR;
        end else begin
          state_d = DP_ENG;
          eng_d   = idx[3:0];
        end
      end else begin
        state_d = DP_NONE;
      end
    end else if (state_q == DP_ERR1) begin
      state_d = DP_ERR2;
    end
  end

  always_comb begin
    csr_wr      = (state_q == DP_CSR) && wr_q;
    csr_wdata   = hwdata[NUM_SLV-1:0];
    mask_d      = (csr_wr && off_q == 2'd1) ? csr_wdata : mask_q;
    w1c         = (csr_wr && off_q == 2'd0) ? csr_wdata : '0;
    intr_prev_d = s_intr;
    // A new edge outranks a simultaneous W1C of the same bit.
    if (INT_EDGE) begin
      pending_d = (pending_q & ~w1c) | (s_intr & ~intr_prev_q);
    end else begin
      pending_d = s_intr;
    end
    irq_d = |(pending_q & mask_q);
  end

  always_ff @(posedge hclk or negedge hrst_b) begin
    if (!hrst_b) begin
      state_q     <= DP_NONE;
      eng_q       <= '0;
      off_q       <= '0;
      wr_q        <= 1'b0;
      mask_q      <= '0;
      pending_q   <= '0;
      intr_prev_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      eng_q       <= eng_d;
      off_q       <= off_d;
      wr_q        <= wr_d;
      mask_q      <= mask_d;
      pending_q   <= pending_d;
      intr_prev_q <= intr_prev_d;
      irq_q       <= irq_d;
    end
  end

endmodule

// File: tb/tb_ahb_crypto_fabric.sv
// Bench for ahb_crypto_fabric: single-transfer AHB driver, bench-driven engines,
// expected read responses queued at issue and compared on completion.
module tb_ahb_crypto_fabric;

  localparam int NS = 3;

  logic               hclk, hrst_b, hsel, hwrite, hready, irq;
  logic [31:0]        haddr, hwdata, hrdata;
  logic [1:0]         htrans, hresp;
  logic [2:0]         hsize;
  logic [3:0]         hprot;
  logic [NS-1:0]      s_hsel, s_hready, s_intr;
  logic [32*NS-1:0]   s_hrdata;
  logic [2*NS-1:0]    s_hresp;

  int checks   = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  ahb_crypto_fabric #(.NUM_SLV(NS)) dut (
    .hclk(hclk), .hrst_b(hrst_b), .hsel(hsel), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hprot(hprot), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp), .s_hsel(s_hsel),
    .s_hrdata(s_hrdata), .s_hready(s_hready), .s_hresp(s_hresp),
    .s_intr(s_intr), .irq(irq)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                          input int eng_waits, output logic [31:0] rdata, output logic [1:0] resp,
                          output logic [1:0] resp_first, output logic [NS-1:0] sel, output int waits);
    int remaining;
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = addr; htrans = 2'b10; hwrite = wr;
    @(negedge hclk);
    sel = s_hsel;
    remaining = eng_waits;
    waits = 0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = wdata;
    s_hready = (remaining > 0) ? '0 : '1;
    @(negedge hclk);
    resp_first = hresp;
    while (!hready && waits < 20) begin
      waits++;
      remaining--;
      @(posedge hclk); #1;
      s_hready = (remaining > 0) ? '0 : '1;
      @(negedge hclk);
    end
    check_val("xfer_done", {63'h0, hready}, 64'h1);
    rdata = hrdata;
    resp  = hresp;
  endtask

  task automatic sb_read(input string tag, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int eng_waits, input logic [NS-1:0] exp_sel,
                         output logic [1:0] resp_first, output int waits);
    logic [31:0] rd;
    logic [1:0]  rs;
    logic [NS-1:0] sl;
    logic [33:0] exp;
    exp_q.push_back({exp_resp, exp_data});
    ahb_xfer(addr, 1'b0, 32'h0, eng_waits, rd, rs, resp_first, sl, waits);
    exp = exp_q.pop_front();
    check_val({tag, "_rsp"}, {30'h0, rs, rd}, {30'h0, exp});
    check_val({tag, "_sel"}, 64'(sl), 64'(exp_sel));
  endtask

  task automatic ahb_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] rd;
    logic [1:0]  rs, rf;
    logic [NS-1:0] sl;
    int w;
    ahb_xfer(addr, 1'b1, data, 0, rd, rs, rf, sl, w);
    check_val({tag, "_okay"}, 64'(rs), 64'h0);
  endtask

  localparam logic [31:0] CSR = 32'h2005_0000;

  initial begin
    logic [1:0] rf;
    int w;
    logic [31:0] mask_model;

    hrst_b = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hprot = 4'h3; hwdata = '0; s_hready = '1; s_hresp = '0; s_intr = '0;
    for (int i = 0; i < NS; i++) s_hrdata[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    mask_model = 32'h0;

    #12;
    check_val("rst_hready", {63'h0, hready}, 64'h1);
    check_val("rst_hresp", 64'(hresp), 64'h0);
    check_val("rst_hrdata", 64'(hrdata), 64'h0);
    check_val("rst_irq", {63'h0, irq}, 64'h0);
    @(posedge hclk); #1;
    hrst_b = 1'b1;

    sb_read("eng1_wait", 32'h2003_0010, 32'hA5A5_0001, 2'b00, 2, 3'b010, rf, w);
    check_val("eng1_waits", 64'(w), 64'd2);
    sb_read("eng0", 32'h2002_0000, 32'hA5A5_0000, 2'b00, 0, 3'b001, rf, w);
    sb_read("eng2", 32'h2004_0004, 32'hA5A5_0002, 2'b00, 1, 3'b100, rf, w);
    check_val("eng2_waits", 64'(w), 64'd1);

    sb_read("unmapped_hi", 32'h2006_0000, 32'h0, 2'b01, 0, 3'b000, rf, w);
    check_val("unmapped_hi_c1", {62'h0, rf}, 64'h1);
    check_val("unmapped_hi_wait", 64'(w), 64'd1);
    sb_read("after_err", 32'h2002_0000, 32'hA5A5_0000, 2'b00, 0, 3'b001, rf, w);
    sb_read("unmapped_lo", 32'h1000_0000, 32'h0, 2'b01, 0, 3'b000, rf, w);

    // Two unmapped transfers back to back: second address held through ERR1, taken in ERR2.
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = 32'h2007_0000; htrans = 2'b10;
    @(posedge hclk); #1;
    haddr = 32'h2008_0000;
    @(negedge hclk); check_val("b2b_a_c1", {61'h0, hready, hresp}, 64'h1);
    @(posedge hclk); #1;
    @(negedge hclk); check_val("b2b_a_c2", {61'h0, hready, hresp}, 64'h5);
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk); check_val("b2b_b_c1", {61'h0, hready, hresp}, 64'h1);
    @(posedge hclk); #1;
    @(negedge hclk); check_val("b2b_b_c2", {61'h0, hready, hresp}, 64'h5);
    @(posedge hclk); #1;
    @(negedge hclk); check_val("b2b_done", {61'h0, hready, hresp}, 64'h4);

    mask_model = 32'h5;
    ahb_write("wr_mask", CSR + 32'h4, mask_model);
    sb_read("rd_mask", CSR + 32'h4, mask_model, 2'b00, 0, 3'b000, rf, w);

    @(posedge hclk); #1; s_intr = 3'b100;
    @(posedge hclk); #1; s_intr = 3'b000;
    @(negedge hclk); check_val("irq_lag", {63'h0, irq}, 64'h0);
    @(negedge hclk); check_val("irq_set", {63'h0, irq}, 64'h1);
    sb_read("status_4", CSR, 32'h4, 2'b00, 0, 3'b000, rf, w);
    ahb_write("w1c_4", CSR, 32'h4);
    @(negedge hclk); check_val("irq_hold", {63'h0, irq}, 64'h1);
    @(negedge hclk); check_val("irq_clr", {63'h0, irq}, 64'h0);
    sb_read("status_0", CSR, 32'h0, 2'b00, 0, 3'b000, rf, w);

    @(posedge hclk); #1; s_intr = 3'b001;
    @(posedge hclk); #1; s_intr = 3'b000;
    sb_read("status_1", CSR, 32'h1, 2'b00, 0, 3'b000, rf, w);
    @(posedge hclk); #1;
    hsel = 1'b1; haddr = CSR; htrans = 2'b10; hwrite = 1'b1;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1; s_intr = 3'b001;
    @(posedge hclk); #1; s_intr = 3'b000;
    sb_read("set_wins", CSR, 32'h1, 2'b00, 0, 3'b000, rf, w);
    ahb_write("w1c_1", CSR, 32'h1);
    sb_read("status_clr", CSR, 32'h0, 2'b00, 0, 3'b000, rf, w);

    sb_read("cfg", CSR + 32'hC, 32'h0000_0203, 2'b00, 0, 3'b000, rf, w);
    ahb_write("wr_cfg", CSR + 32'hC, 32'hFFFF_FFFF);
    sb_read("cfg_again", CSR + 32'hC, 32'h0000_0203, 2'b00, 0, 3'b000, rf, w);

    @(posedge hclk); #1; s_intr = 3'b101;
    sb_read("raw", CSR + 32'h8, 32'h5, 2'b00, 0, 3'b000, rf, w);
    s_intr = 3'b000;
    @(negedge hclk); check_val("irq_pre_rst", {63'h0, irq}, 64'h1);

    @(posedge hclk); #1;
    hsel = 1'b1; haddr = 32'h2006_0000; htrans = 2'b10;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge hclk); check_val("rst_err_c1", {61'h0, hready, hresp}, 64'h1);
    #1 hrst_b = 1'b0;
    #1;
    check_val("rst_mid_hready", {63'h0, hready}, 64'h1);
    check_val("rst_mid_hresp", 64'(hresp), 64'h0);
    check_val("rst_mid_irq", {63'h0, irq}, 64'h0);
    @(posedge hclk); #1; hrst_b = 1'b1;
    mask_model = 32'h0;
    sb_read("mask_rst", CSR + 32'h4, mask_model, 2'b00, 0, 3'b000, rf, w);
    sb_read("status_rst", CSR, 32'h0, 2'b00, 0, 3'b000, rf, w);
    sb_read("eng1_post", 32'h2003_0000, 32'hA5A5_0001, 2'b00, 0, 3'b010, rf, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
